// File: rtl/demo_seq_pkg.sv
// Shared types and the default scene table for the demo scene sequencer.
package demo_seq_pkg;

   localparam int unsigned CTRL_W = 8;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned DUR_W  = 16;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PAUSE  = 2'd1,
      MANUAL = 2'd2,
      SEP    = 2'd3
   } seq_state_e;

   // vga_control field layout, LSB first: bg_mode[3:0], loop_mode, sprite_sel, reserved[7:6]
   typedef struct packed {
      logic [1:0] rsvd;
      logic       sprite_sel;
      logic       loop_mode;
      logic [3:0] bg_mode;
   } vga_ctrl_t;

   typedef struct packed {
      vga_ctrl_t        ctrl;
      logic [DUR_W-1:0] frames;
   } scene_t;

   // Black background shown between scenes when separators are enabled
   localparam logic [CTRL_W-1:0] SEP_CTRL = 8'h0F;

   function automatic scene_t default_scene(input logic [IDX_W-1:0] idx);
      scene_t s;
      case (idx)
         4'd0:    s = {8'h00, 16'd60};
         4'd1:    s = {8'h01, 16'd60};
         4'd2:    s = {8'h02, 16'd60};
         4'd3:    s = {8'h03, 16'd60};
         4'd4:    s = {8'h05, 16'd60};
         4'd5:    s = {8'h07, 16'd60};
         4'd6:    s = {8'h2A, 16'd60};
         4'd7:    s = {8'h10, 16'd240};
         default: s = {8'h00, 16'd60};
      endcase
      return s;
   endfunction

endpackage

// File: rtl/demo_scene_rom.sv
// Combinational scene table lookup; kept separate so it can become a RAM later.
module demo_scene_rom
   import demo_seq_pkg::*;
(
   input  logic [IDX_W-1:0]  idx,
   output logic [CTRL_W-1:0] ctrl_c,
   output logic [DUR_W-1:0]  frames_c
);

   scene_t    entry;
   vga_ctrl_t ctrl_v;

   // Reserved control bits are never driven from the table
   always_comb begin
      entry       = default_scene(idx);
      ctrl_v      = entry.ctrl;
      ctrl_v.rsvd = '0;
   end

   assign ctrl_c   = ctrl_v;
   assign frames_c = entry.frames;

endmodule

// File: rtl/demo_sequencer.sv
// Frame-synchronous scene scheduler driving vga_control, with pause, skip and manual override.
// Build option: define SEQ_SEP_EN to insert SEP_FRAMES black separator frames before each advance.
module demo_sequencer
   import demo_seq_pkg::*;
#(
   parameter int unsigned NUM_SCENES = 8,
   parameter int unsigned FRAME_W    = 8
`ifdef SEQ_SEP_EN
   ,
   parameter int unsigned SEP_FRAMES = 2
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              pause,
   input  logic              skip,
   input  logic              manual_en,
   input  logic [CTRL_W-1:0] manual_ctrl,
   output logic [CTRL_W-1:0] vga_control,
   output logic [IDX_W-1:0]  scene_idx,
   output logic              scene_change
);

   localparam int unsigned      CMP_W    = (FRAME_W > DUR_W) ? FRAME_W : DUR_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SCENES - 1);
   localparam scene_t           SCENE0   = default_scene(IDX_W'(0));

`ifdef SEQ_SEP_EN
   localparam int unsigned        SEP_W    = 8;
   localparam logic [SEP_W-1:0]   SEP_LAST = (SEP_FRAMES == 0) ? '0 : SEP_W'(SEP_FRAMES - 1);
   logic [SEP_W-1:0] sep_cnt, sep_cnt_nxt;
`endif

   seq_state_e        state, state_nxt;
   logic [IDX_W-1:0]  idx_nxt, adv_idx;
   logic [FRAME_W-1:0] frame_cnt, cnt_nxt, cnt_sat;
   logic [DUR_W-1:0]  cur_frames, limit, rom_frames_c;
   logic [CTRL_W-1:0] ctrl_pre, ctrl_nxt, rom_ctrl_c;
   logic              skip_pending, skip_nxt, skip_eff;
   logic              load, expired;

   // Table is read at the next index so the new entry is ready on the loading edge
   demo_scene_rom u_rom (
      .idx      (idx_nxt),
      .ctrl_c   (rom_ctrl_c),
      .frames_c (rom_frames_c)
   );

   // Zero-length scenes last one frame; counter saturates instead of wrapping
   assign limit   = (cur_frames == '0) ? '0 : cur_frames - DUR_W'(1);
   assign expired = (CMP_W'(frame_cnt) == CMP_W'(limit));
   assign cnt_sat = (frame_cnt == '1) ? frame_cnt : frame_cnt + FRAME_W'(1);
   assign adv_idx = (scene_idx >= LAST_IDX) ? '0 : scene_idx + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= RUN;
         scene_idx    <= '0;
         frame_cnt    <= '0;
         vga_control  <= SCENE0.ctrl;
         cur_frames   <= SCENE0.frames;
         scene_change <= 1'b0;
         skip_pending <= 1'b0;
`ifdef SEQ_SEP_EN
         sep_cnt      <= '0;
`endif
      end else begin
         state        <= state_nxt;
         scene_idx    <= idx_nxt;
         frame_cnt    <= cnt_nxt;
         vga_control  <= ctrl_nxt;
         cur_frames   <= rom_frames_c;
         scene_change <= load;
         skip_pending <= skip_nxt;
`ifdef SEQ_SEP_EN
         sep_cnt      <= sep_cnt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = scene_idx;
      cnt_nxt   = frame_cnt;
      ctrl_pre  = vga_control;
      load      = 1'b0;
      skip_eff  = skip_pending | skip;
      skip_nxt  = skip_eff;
`ifdef SEQ_SEP_EN
      sep_cnt_nxt = sep_cnt;
`endif
      if (state == SEP) skip_nxt = 1'b0;

      if (frame_start) begin
         case (state)
            RUN, PAUSE: begin
               if (manual_en) begin
                  state_nxt = MANUAL;
                  ctrl_pre  = manual_ctrl;
               end else if (skip_eff || (state == RUN && expired)) begin
                  skip_nxt = 1'b0;
                  idx_nxt  = adv_idx;
                  cnt_nxt  = '0;
`ifdef SEQ_SEP_EN
                  state_nxt   = SEP;
                  sep_cnt_nxt = '0;
                  ctrl_pre    = SEP_CTRL;
`else
                  load = 1'b1;
`endif
               end else if (state == RUN) begin
                  if (pause) state_nxt = PAUSE;
                  else       cnt_nxt   = cnt_sat;
               end else if (!pause) begin
                  state_nxt = RUN;
               end
            end
            MANUAL: begin
               skip_nxt = 1'b0;
               if (manual_en) begin
                  ctrl_pre = manual_ctrl;
               end else begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
                  load      = 1'b1;
               end
            end
            default: begin
`ifdef SEQ_SEP_EN
               // Index already advanced on entry; load its entry once the gap ends
               if (manual_en) begin
                  state_nxt = MANUAL;
                  ctrl_pre  = manual_ctrl;
               end else if (sep_cnt >= SEP_LAST) begin
                  state_nxt = pause ? PAUSE : RUN;
                  load      = 1'b1;
               end else begin
                  sep_cnt_nxt = sep_cnt + SEP_W'(1);
               end
`else
               state_nxt = RUN;
`endif
            end
         endcase
      end
   end

   assign ctrl_nxt = load ? rom_ctrl_c : ctrl_pre;

endmodule
